// File: rtl/dvp_pattern_tx.sv
// dvp_pattern_tx: OV7670-style DVP source. Generates pclk/vsync/href and
// RGB565 byte data from built-in patterns or an external pixel read port.
module dvp_pattern_tx #(
  parameter int PCLK_DIV    = 2,
  parameter int H_ACTIVE    = 320,
  parameter int V_ACTIVE    = 240,
  parameter int H_BLANK     = 144,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  pattern_sel,
  input  logic [15:0] pix_data,
  output logic        pclk_cam,
  output logic        vsync_cam,
  output logic        href_cam,
  output logic [7:0]  wdata_cam,
  output logic        pix_req,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        busy,
  output logic        frame_done
);

  localparam int LINE    = 2*H_ACTIVE + H_BLANK;
  localparam int HW      = $clog2(LINE + 1);
  localparam int VM0     = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
  localparam int VM1     = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int VMAX    = (VM0 > VM1) ? VM0 : VM1;
  localparam int VW      = (VMAX > 1) ? $clog2(VMAX) : 1;
  localparam int DW      = $clog2(PCLK_DIV);
  localparam int BAR_W   = H_ACTIVE / 8;
  localparam int BAR_DIV = (BAR_W == 0) ? 1 : BAR_W;

  localparam logic [HW-1:0] H_LAST   = HW'(LINE - 1);
  localparam logic [HW-1:0] H_HREF   = HW'(2*H_ACTIVE);
  localparam logic [DW-1:0] DIV_LAST = DW'(PCLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} state_t;

  state_t          state, state_n;
  logic [HW-1:0]   hcnt, hcnt_n, x_n;
  logic [VW-1:0]   vcnt, vcnt_n, seg_last;
  logic [DW-1:0]   div_cnt;
  logic [1:0]      pat_q;
  logic [15:0]     pix_val, pix_hold;
  logic            frame_end, href_n, req_n;
  logic            tick, pclk_rise, pclk_fall;

  // Colour bar lookup; columns past the last full bar are black.
  function automatic logic [15:0] bar_color(input int unsigned x);
    logic [15:0] c;
    c = 16'h0000;
    if (x < unsigned'(8*BAR_W)) begin
      case (x / unsigned'(BAR_DIV))
        0:       c = 16'hFFFF;
        1:       c = 16'hFFE0;
        2:       c = 16'h07FF;
        3:       c = 16'h07E0;
        4:       c = 16'hF81F;
        5:       c = 16'hF800;
        6:       c = 16'h001F;
        default: c = 16'h0000;
      endcase
    end
    return c;
  endfunction

  assign tick      = (div_cnt == DIV_LAST);
  assign pclk_rise = tick && !pclk_cam;
  assign pclk_fall = tick && pclk_cam;

  // Next position at the coming pclk fall; counters only move on falls,
  // so the same values also predict the next pixel at the preceding rise.
  always_comb begin
    state_n   = state;
    hcnt_n    = hcnt;
    vcnt_n    = vcnt;
    frame_end = 1'b0;
    case (state)
      VSYNC:   seg_last = VW'(VSYNC_LINES - 1);
      VBACK:   seg_last = VW'(V_BACK - 1);
      ACTIVE:  seg_last = VW'(V_ACTIVE - 1);
      VFRONT:  seg_last = VW'(V_FRONT - 1);
      default: seg_last = '0;
    endcase
    if (state == IDLE) begin
      hcnt_n = '0;
      vcnt_n = '0;
      if (en) state_n = VSYNC;
    end else if (hcnt == H_LAST) begin
      hcnt_n = '0;
      if (vcnt == seg_last) begin
        vcnt_n = '0;
        case (state)
          VSYNC:   state_n = VBACK;
          VBACK:   state_n = ACTIVE;
          ACTIVE:  state_n = VFRONT;
          default: begin
            frame_end = 1'b1;
            state_n   = en ? VSYNC : IDLE;
          end
        endcase
      end else begin
        vcnt_n = vcnt + 1'b1;
      end
    end else begin
      hcnt_n = hcnt + 1'b1;
    end
  end

  // Pixel source for the pixel at the next position.
  always_comb begin
    x_n    = hcnt_n >> 1;
    href_n = (state_n == ACTIVE) && (hcnt_n < H_HREF);
    req_n  = href_n && !hcnt_n[0] && (pat_q == 2'd3);
    case (pat_q)
      2'd0:    pix_val = 16'hFFFF;
      2'd1:    pix_val = bar_color(32'(x_n));
      2'd2:    pix_val = 16'(x_n) + 16'(vcnt_n);
      default: pix_val = pix_data;
    endcase
  end

  // FSM state and frame counters, stepped on pclk falls.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state <= IDLE;
      hcnt  <= '0;
      vcnt  <= '0;
    end else if (pclk_fall) begin
      state <= state_n;
      hcnt  <= hcnt_n;
      vcnt  <= vcnt_n;
    end
  end

  // Free-running pclk divider.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      div_cnt  <= '0;
      pclk_cam <= 1'b0;
    end else if (tick) begin
      div_cnt  <= '0;
      pclk_cam <= ~pclk_cam;
    end else begin
      div_cnt  <= div_cnt + 1'b1;
    end
  end

  // DVP outputs launched on pclk falls; external requests issued on rises.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      vsync_cam  <= 1'b0;
      href_cam   <= 1'b0;
      wdata_cam  <= '0;
      pix_req    <= 1'b0;
      pix_x      <= '0;
      pix_y      <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      pat_q      <= '0;
      pix_hold   <= '0;
    end else begin
      pix_req    <= 1'b0;
      frame_done <= 1'b0;
      if (pclk_rise && req_n) begin
        pix_req <= 1'b1;
        pix_x   <= 10'(x_n);
        pix_y   <= 10'(vcnt_n);
      end
      if (pclk_fall) begin
        if (state_n == VSYNC && state != VSYNC) pat_q <= pattern_sel;
        vsync_cam  <= (state_n == VSYNC);
        href_cam   <= href_n;
        busy       <= (state_n != IDLE);
        frame_done <= frame_end;
        if (!href_n) begin
          wdata_cam <= '0;
        end else if (!hcnt_n[0]) begin
          wdata_cam <= pix_val[15:8];
          pix_hold  <= pix_val;
        end else begin
          wdata_cam <= pix_hold[7:0];
        end
      end
    end
  end

endmodule
